// File: rtl/fd_instr_queue_pkg.sv
// Shared definitions for the fetch/decode decoupling queue.
// FD_RESET_PC / FD_NOP_INSTR are also used by the fetch stage, so the
// queue's empty-state bubble matches fetch's reset PC.
// fd_entry_t is one queue slot: {pc, instr}, 64 bits.
package fd_instr_queue_pkg;

   localparam logic [31:0] FD_RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] FD_NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fd_entry_t;

endpackage

// File: rtl/fd_instr_queue_if.sv
// Fetch/decode handshake bundle for fd_instr_queue.
//   F_PC, F_Instr, f_valid : fetch -> queue offer
//   f_ready                : queue -> fetch (PC write-enable)
//   D_PC, D_Instr, d_valid : queue -> decode head entry
//   d_ready                : decode -> queue consume
//   flush                  : redirect, discard all entries
//   count                  : queue occupancy
// slave  = the queue's view, master = the surrounding pipeline's view.
interface fd_instr_queue_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [31:0]   F_PC;
   logic [31:0]   F_Instr;
   logic          f_valid;
   logic          f_ready;
   logic [31:0]   D_PC;
   logic [31:0]   D_Instr;
   logic          d_valid;
   logic          d_ready;
   logic          flush;
   logic [CW-1:0] count;

   modport slave (
      input  F_PC, F_Instr, f_valid, d_ready, flush,
      output f_ready, D_PC, D_Instr, d_valid, count
   );

   modport master (
      output F_PC, F_Instr, f_valid, d_ready, flush,
      input  f_ready, D_PC, D_Instr, d_valid, count
   );

endinterface

// File: rtl/fd_queue_ctrl.sv
// Pointer / occupancy control for fd_instr_queue.
//   clk, reset     : clock, async active-low reset
//   f_valid_i      : fetch offers an entry
//   d_ready_i      : decode consumes the head
//   flush_i        : discard all entries (priority over push/pop)
//   f_ready_o      : not full
//   d_valid_o      : not empty
//   wr_en_o        : write storage at wp_o this edge
//   wp_o, rp_o     : write / read pointers
//   count_o        : occupancy 0..DEPTH
module fd_queue_ctrl #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       f_valid_i,
   input  logic                       d_ready_i,
   input  logic                       flush_i,
   output logic                       f_ready_o,
   output logic                       d_valid_o,
   output logic                       wr_en_o,
   output logic [$clog2(DEPTH)-1:0]   wp_o,
   output logic [$clog2(DEPTH)-1:0]   rp_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push;
   logic          pop;

   // Ready/valid come only from registered cnt: no d_ready -> f_ready path.
   assign f_ready_o = (cnt_q != CNT_FULL);
   assign d_valid_o = (cnt_q != '0);

   assign push = f_valid_i & f_ready_o;
   assign pop  = d_valid_o & d_ready_i;

   assign wr_en_o = push & ~flush_i;

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wp_d = wp_q + PTR_ONE;
         if (pop)  rp_d = rp_q + PTR_ONE;
         if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
         else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   assign wp_o    = wp_q;
   assign rp_o    = rp_q;
   assign count_o = cnt_q;

endmodule

// File: rtl/fd_instr_queue.sv
// Fetch -> decode decoupling queue.
// Captures (PC, instr) pairs from fetch and presents the oldest to decode;
// backpressures fetch when full and discards everything on flush.
//   clk   : clock
//   reset : async active-low reset
//   q_if  : fd_instr_queue_if.slave (fetch offer, decode head, flush, count)
module fd_instr_queue
   import fd_instr_queue_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = FD_RESET_PC,
   parameter logic [31:0] NOP_INSTR = FD_NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   fd_instr_queue_if.slave q_if
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic          wr_en;
   logic          d_valid;
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   fd_entry_t     mem_q [DEPTH];
   fd_entry_t     head;

   fd_queue_ctrl #(
      .DEPTH (DEPTH)
   ) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .f_valid_i (q_if.f_valid),
      .d_ready_i (q_if.d_ready),
      .flush_i   (q_if.flush),
      .f_ready_o (q_if.f_ready),
      .d_valid_o (d_valid),
      .wr_en_o   (wr_en),
      .wp_o      (wp),
      .rp_o      (rp),
      .count_o   (q_if.count)
   );

   // Storage is deliberately not reset; the d_valid mux hides stale slots.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wp] <= '{pc: q_if.F_PC, instr: q_if.F_Instr};
      end
   end

   assign head = mem_q[rp];

   assign q_if.d_valid = d_valid;
   assign q_if.D_PC    = d_valid ? head.pc    : RESET_PC;
   assign q_if.D_Instr = d_valid ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_fd_instr_queue.sv
module tb_fd_instr_queue;
   import fd_instr_queue_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fd_instr_queue_if #(.DEPTH(DEPTH)) bus();

   fd_instr_queue #(
      .DEPTH     (DEPTH),
      .RESET_PC  (32'h0000_3000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .q_if  (bus)
   );

   typedef struct {
      logic        fv;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        dr;
      logic        fl;
      int unsigned e_cnt;
      logic        e_dv;
      logic        e_fr;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
   } vec_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [31:0] ins_of(input logic [31:0] pc);
      return {~pc[15:0], pc[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic dr, input logic fl, input int unsigned ec,
                      input logic edv, input logic efr, input logic [31:0] epc,
                      input logic [31:0] eins);
      vec_t v;
      v.fv = fv; v.pc = pc; v.ins = ins; v.dr = dr; v.fl = fl;
      v.e_cnt = ec; v.e_dv = edv; v.e_fr = efr; v.e_pc = epc; v.e_ins = eins;
      vecs.push_back(v);
   endtask

   // Compare DUT outputs against the scoreboard contents.
   task automatic sb_check(input string tag);
      chk({tag, "_sb_count"},   32'(bus.count),   32'(sb.size()));
      chk({tag, "_sb_dvalid"},  32'(bus.d_valid), 32'(sb.size() != 0));
      chk({tag, "_sb_fready"},  32'(bus.f_ready), 32'(sb.size() != DEPTH));
      if (sb.size() != 0) begin
         chk({tag, "_sb_pc"},    bus.D_PC,    sb[0].pc);
         chk({tag, "_sb_instr"}, bus.D_Instr, sb[0].ins);
      end else begin
         chk({tag, "_sb_pc"},    bus.D_PC,    32'h0000_3000);
         chk({tag, "_sb_instr"}, bus.D_Instr, 32'h0000_0000);
      end
   endtask

   // Drive one cycle of inputs, update the scoreboard for the coming edge,
   // then sample #1 after the edge.
   task automatic drive_cycle(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                              input logic dr, input logic fl, input string tag);
      bit do_push;
      bit do_pop;
      sb_t e;
      bus.f_valid = fv;
      bus.F_PC    = pc;
      bus.F_Instr = ins;
      bus.d_ready = dr;
      bus.flush   = fl;
      do_push = fv && (sb.size() != DEPTH);
      do_pop  = dr && (sb.size() != 0);
      if (fl) begin
         sb.delete();
      end else begin
         if (do_pop) void'(sb.pop_front());
         if (do_push) begin
            e.pc  = pc;
            e.ins = ins;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      sb_check(tag);
   endtask

   initial begin
      bus.f_valid = 1'b0;
      bus.F_PC    = '0;
      bus.F_Instr = '0;
      bus.d_ready = 1'b0;
      bus.flush   = 1'b0;
      reset       = 1'b0;

      // Vector table: inputs for one edge and the state expected after it.
      add(1, 32'h3000, 32'h3c010001, 0, 0, 1, 1, 1, 32'h3000, 32'h3c010001);
      add(0, 32'h0,    32'h0,        1, 0, 0, 0, 1, 32'h3000, 32'h0);
      for (int unsigned k = 0; k < 4; k++)
         add(1, 32'h3000 + 4*k, ins_of(32'h3000 + 4*k), 0, 0, k + 1, 1, (k != 3),
             32'h3000, ins_of(32'h3000));
      add(1, 32'h3010, ins_of(32'h3010), 0, 0, 4, 1, 0, 32'h3000, ins_of(32'h3000));
      add(1, 32'h3010, ins_of(32'h3010), 1, 0, 3, 1, 1, 32'h3004, ins_of(32'h3004));
      add(1, 32'h3010, ins_of(32'h3010), 0, 0, 4, 1, 0, 32'h3004, ins_of(32'h3004));
      add(0, 32'h0, 32'h0, 1, 0, 3, 1, 1, 32'h3008, ins_of(32'h3008));
      add(0, 32'h0, 32'h0, 1, 0, 2, 1, 1, 32'h300c, ins_of(32'h300c));
      for (int unsigned i = 0; i < 10; i++)
         add(1, 32'h3014 + 4*i, ins_of(32'h3014 + 4*i), 1, 0, 2, 1, 1,
             32'h3010 + 4*i, ins_of(32'h3010 + 4*i));
      add(1, 32'h303c, ins_of(32'h303c), 0, 0, 3, 1, 1, 32'h3034, ins_of(32'h3034));
      add(1, 32'h3040, ins_of(32'h3040), 1, 1, 0, 0, 1, 32'h3000, 32'h0);
      add(1, 32'h3044, ins_of(32'h3044), 0, 0, 1, 1, 1, 32'h3044, ins_of(32'h3044));
      add(1, 32'h3048, ins_of(32'h3048), 0, 0, 2, 1, 1, 32'h3044, ins_of(32'h3044));
      add(1, 32'h304c, ins_of(32'h304c), 0, 0, 3, 1, 1, 32'h3044, ins_of(32'h3044));

      // Power-on reset state.
      #12;
      chk("por_dvalid", 32'(bus.d_valid), 32'd0);
      chk("por_count",  32'(bus.count),   32'd0);
      chk("por_fready", 32'(bus.f_ready), 32'd1);
      chk("por_pc",     bus.D_PC,         32'h0000_3000);
      chk("por_instr",  bus.D_Instr,      32'h0000_0000);
      @(posedge clk);
      #1;
      reset = 1'b1;

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("v%0d", i);
         drive_cycle(vecs[i].fv, vecs[i].pc, vecs[i].ins, vecs[i].dr, vecs[i].fl, tag);
         chk({tag, "_count"},  32'(bus.count),   32'(vecs[i].e_cnt));
         chk({tag, "_dvalid"}, 32'(bus.d_valid), 32'(vecs[i].e_dv));
         chk({tag, "_fready"}, 32'(bus.f_ready), 32'(vecs[i].e_fr));
         chk({tag, "_pc"},     bus.D_PC,         vecs[i].e_pc);
         chk({tag, "_instr"},  bus.D_Instr,      vecs[i].e_ins);
      end

      // Asynchronous reset mid-cycle with 3 entries queued.
      bus.f_valid = 1'b0;
      bus.d_ready = 1'b0;
      bus.flush   = 1'b0;
      chk("pre_rst_count", 32'(bus.count), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      sb.delete();
      chk("arst_dvalid", 32'(bus.d_valid), 32'd0);
      chk("arst_count",  32'(bus.count),   32'd0);
      chk("arst_fready", 32'(bus.f_ready), 32'd1);
      chk("arst_pc",     bus.D_PC,         32'h0000_3000);
      chk("arst_instr",  bus.D_Instr,      32'h0000_0000);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Queue works again after reset; head is the new entry.
      drive_cycle(1, 32'h3100, ins_of(32'h3100), 0, 0, "post_rst_push");
      chk("post_rst_pc", bus.D_PC, 32'h3100);
      drive_cycle(0, 32'h0, 32'h0, 1, 0, "post_rst_pop");
      chk("post_rst_empty", 32'(bus.d_valid), 32'd0);

      // Pop request on an empty queue must be ignored.
      drive_cycle(0, 32'h0, 32'h0, 1, 0, "empty_pop");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fd_instr_queue.md
Name: fd_instr_queue

Overview:
- Decoupling queue between the fetch stage (PC register + instruction ROM) and the decode stage.
- Captures each fetched (PC, instruction) pair and presents the oldest one to decode.
- Backpressures fetch when full, so fetch's PC write-enable comes from this block's f_ready.
- Supports a flush for branch/jump redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- RESET_PC, 32'h00003000, value driven on D_PC when the queue is empty.
- NOP_INSTR, 32'h00000000, value driven on D_Instr when the queue is empty.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- F_PC  input  32  PC of the instruction being fetched.
- F_Instr  input  32  instruction word at F_PC.
- f_valid  input  1  fetch offers (F_PC, F_Instr) this cycle.
- f_ready  output  1  queue accepts a push this cycle; drives fetch's PC write-enable.
- D_PC  output  32  PC of the head entry.
- D_Instr  output  32  instruction of the head entry.
- d_valid  output  1  head entry is valid.
- d_ready  input  1  decode consumes the head this cycle.
- flush  input  1  discard all entries (redirect).
- count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH x 64-bit array (PC, instr). Write pointer wp, read pointer rp, each clog2(DEPTH) bits, wrapping naturally modulo DEPTH. Occupancy counter cnt holds 0..DEPTH.
- Reset (reset=0, asynchronous):
  - wp=rp=0, cnt=0.
  - Outputs: d_valid=0, f_ready=1, count=0, D_PC=RESET_PC, D_Instr=NOP_INSTR.
  - Reset asserted mid-operation drops all entries at once, without waiting for a clock edge.
- Handshakes:
  - push = f_valid & f_ready.
  - pop = d_valid & d_ready.
- Ready/valid decoding:
  - f_ready = (cnt != DEPTH). It depends only on registered state; there is no combinational path from d_ready to f_ready.
  - d_valid = (cnt != 0).
- Output mux:
  - d_valid=1: D_PC/D_Instr = entry[rp].
  - d_valid=0: RESET_PC/NOP_INSTR, so decode sees a nop bubble.
- Latency: an entry pushed at edge N is visible on D_* from edge N, i.e. it can pop at edge N+1. There is no bypass on an empty queue.
- Per rising edge, flush=0:
  - push only: store at wp, wp+1, cnt+1.
  - pop only: rp+1, cnt-1.
  - push and pop: both pointers advance, cnt unchanged. This is legal at any non-full, non-empty occupancy. On an empty queue, pop cannot occur.
  - Full: push cannot occur (f_ready=0); a pop alone frees the slot, and f_ready=1 on the next cycle.
- flush=1 on an edge:
  - wp=rp=0, cnt=0.
  - A simultaneous push is dropped and a simultaneous pop is ignored; flush has priority over both.
  - Next cycle: d_valid=0, f_ready=1.
  - The delay-slot instruction is the redirecting unit's responsibility; it must not flush until the delay slot has been popped.
- Pointer wrap: wp/rp from DEPTH-1 go to 0. cnt disambiguates full from empty when wp==rp.
- Storage contents are not cleared on reset or flush; only pointers and cnt are. Outputs never expose stale data because of the d_valid mux.
- count = cnt.

Decomposition:
- Shared package holds:
  - RESET_PC and NOP_INSTR constants, shared with the fetch stage.
  - The {pc, instr} entry struct typedef, 64 bits.
- One natural sub-module: fd_queue_ctrl, holding pointers, cnt, push/pop/flush arbitration, f_ready and d_valid. The top holds the storage array and the output mux.

Test Plan:
- Reset: drive reset=0 mid-run with 3 entries queued -> immediately d_valid=0, count=0, D_PC=32'h00003000, D_Instr=0, f_ready=1.
- Single transfer: push (32'h00003000, 32'h3c010001) with d_ready=0 -> next cycle d_valid=1, D_PC=32'h00003000, D_Instr=32'h3c010001, count=1. Pulse d_ready -> count=0 and nop output.
- Fill/backpressure: push 4 consecutive PCs 3000..300c with d_ready=0 -> count=4, f_ready=0. A 5th f_valid is not accepted. One pop -> f_ready=1 next cycle, head D_PC=3004.
- Simultaneous push and pop at count=2 for 10 cycles -> count stays 2. D_PC sequence is strictly +4 per cycle, and the pointers wrap past entry 3 without loss.
- Flush with push: count=3, flush=1, f_valid=1, d_ready=1 on the same edge -> next cycle count=0, d_valid=0. The pushed entry is absent, and the next push shows up as the head.
- Full with simultaneous pop: count=4, f_valid=1, d_ready=1 -> pop only, count=3. The f_valid word is not taken and is re-offered the next cycle.
